// File: rtl/decode_fetch_queue_if.sv
// Handshake bundle between fetch, the IF/ID instruction queue and decode.
// The queue uses the slave modport and the fetch/decode side uses master.
interface decode_fetch_queue_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              ihit;
    logic [WORD_W-1:0] instr_in;
    logic [WORD_W-1:0] npc_in;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [WORD_W-1:0] instr_out;
    logic [WORD_W-1:0] npc_out;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [WORD_W-1:0] shamt;
    logic [15:0]       imm16;
    logic              halt;
    logic [CNT_W-1:0]  count;

    modport master (
        output ihit, instr_in, npc_in, stall, flush,
        input  in_ready, out_valid, instr_out, npc_out,
               rs, rt, rd, shamt, imm16, halt, count
    );

    modport slave (
        input  ihit, instr_in, npc_in, stall, flush,
        output in_ready, out_valid, instr_out, npc_out,
               rs, rt, rd, shamt, imm16, halt, count
    );
endinterface

// File: rtl/decode_fetch_queue.sv
// DEPTH-entry instruction FIFO at the IF/ID boundary: buffers {instr, nPC},
// presents the head with fields pre-split, with stall, flush and sticky halt.
module decode_fetch_queue #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic                CLK,
    input logic                nRST,
    decode_fetch_queue_if.slave dfq
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [5:0] HALT_OP = 6'h3F;

    logic [WORD_W-1:0] instr_mem_q [DEPTH];
    logic [WORD_W-1:0] npc_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_q, halt_d;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head_instr;

    // Readiness comes from the current count only, so a full queue that pops
    // this cycle still refuses the concurrent push.
    assign in_ready  = (count_q != FULL) && !halt_q;
    assign out_valid = (count_q != '0);
    assign push      = dfq.ihit && in_ready && !dfq.flush;
    assign pop       = out_valid && !dfq.stall && !dfq.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halt_d   = halt_q;
        if (dfq.flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            halt_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (dfq.instr_in[31:26] == HALT_OP) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halt_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halt_q   <= halt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && push) begin
            instr_mem_q[wr_ptr_q] <= dfq.instr_in;
            npc_mem_q[wr_ptr_q]   <= dfq.npc_in;
        end
    end

    // Empty queue reads as a NOP with nPC 0, like the old cleared latch.
    assign head_instr    = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign dfq.instr_out = head_instr;
    assign dfq.npc_out   = out_valid ? npc_mem_q[rd_ptr_q] : '0;
    assign dfq.rs        = head_instr[25:21];
    assign dfq.rt        = head_instr[20:16];
    assign dfq.rd        = head_instr[15:11];
    assign dfq.shamt     = {{(WORD_W-5){1'b0}}, head_instr[10:6]};
    assign dfq.imm16     = head_instr[15:0];
    assign dfq.in_ready  = in_ready;
    assign dfq.out_valid = out_valid;
    assign dfq.halt      = halt_q;
    assign dfq.count     = count_q;
endmodule

// File: tb/tb_decode_fetch_queue.sv
// Bench for decode_fetch_queue: directed stimulus pushes expected entries into
// a scoreboard; a negedge monitor checks every entry decode consumes.
module tb_decode_fetch_queue;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic CLK;
    logic nRST;
    int   n_cmp;
    int   n_err;
    logic [63:0] exp_q [$];

    decode_fetch_queue_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dfq ();

    decode_fetch_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dfq  (dfq.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic hit, input logic [31:0] ins, input logic [31:0] npc);
        dfq.ihit     = hit;
        dfq.instr_in = ins;
        dfq.npc_in   = npc;
    endtask

    task automatic expect_entry(input logic [31:0] ins, input logic [31:0] npc);
        exp_q.push_back({ins, npc});
    endtask

    // An entry presented with no stall/flush is consumed at the next edge.
    always @(negedge CLK) begin
        logic [63:0] e;
        logic [31:0] ei;
        if (nRST && dfq.out_valid && !dfq.stall && !dfq.flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {32'h0, dfq.instr_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e  = exp_q.pop_front();
                ei = e[63:32];
                chk("pop_instr", {32'h0, dfq.instr_out}, {32'h0, ei});
                chk("pop_npc", {32'h0, dfq.npc_out}, {32'h0, e[31:0]});
                chk("pop_fields", {dfq.rs, dfq.rt, dfq.rd, dfq.imm16, dfq.shamt[4:0]},
                    {ei[25:21], ei[20:16], ei[15:11], ei[15:0], ei[10:6]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        nRST = 1'b0;
        dfq.stall = 1'b0;
        dfq.flush = 1'b0;
        drive(1'b0, '0, '0);
        step();
        step();
        chk("rst_valid", dfq.out_valid, 0);
        chk("rst_ready", dfq.in_ready, 1);
        chk("rst_instr", dfq.instr_out, 0);
        chk("rst_npc", dfq.npc_out, 0);
        chk("rst_count", dfq.count, 0);
        chk("rst_halt", dfq.halt, 0);
        chk("rst_fields", {dfq.rs, dfq.rt, dfq.rd, dfq.imm16, dfq.shamt}, 0);
        nRST = 1'b1;

        // 1: pass-through with one-cycle latency
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8C22_0004 + i, 32'(4 * (i + 1)));
            expect_entry(32'h8C22_0004 + i, 32'(4 * (i + 1)));
            step();
            chk("t1_instr", dfq.instr_out, 32'h8C22_0004 + i);
            chk("t1_npc", dfq.npc_out, 4 * (i + 1));
            chk("t1_count", dfq.count, 1);
            if (i == 0) chk("t1_fields", {dfq.rs, dfq.rt, dfq.imm16}, {5'd1, 5'd2, 16'h0004});
        end
        drive(1'b0, '0, '0);
        step();
        chk("t1_drained", {dfq.count, dfq.out_valid}, 0);

        // 2: stall fills queue, extra ihit dropped
        dfq.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0003_1080 + 32'(i * 32'h40), 32'h100 + 32'(4 * i));
            expect_entry(32'h0003_1080 + 32'(i * 32'h40), 32'h100 + 32'(4 * i));
            step();
        end
        chk("t2_full_count", dfq.count, 4);
        chk("t2_full_ready", dfq.in_ready, 0);
        chk("t2_head_fields", {dfq.rs, dfq.rt, dfq.rd, dfq.shamt}, {5'd0, 5'd3, 5'd2, 32'd2});
        drive(1'b1, 32'hDEAD_BEEF, 32'h200);
        step();
        chk("t2_drop_count", dfq.count, 4);
        chk("t2_drop_head", dfq.instr_out, 32'h0003_1080);
        drive(1'b0, '0, '0);
        dfq.stall = 1'b0;
        repeat (4) step();
        chk("t2_drained", dfq.count, 0);

        // 3: full + pop refuses the push, then push+pop holds count
        dfq.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2000_0000 + i, 32'h300 + 32'(4 * i));
            expect_entry(32'h2000_0000 + i, 32'h300 + 32'(4 * i));
            step();
        end
        dfq.stall = 1'b0;
        drive(1'b1, 32'h2000_00B0, 32'h400);
        chk("t3_full_ready", dfq.in_ready, 0);
        step();
        chk("t3_count_4to3", dfq.count, 3);
        chk("t3_ready_again", dfq.in_ready, 1);
        expect_entry(32'h2000_00B0, 32'h400);
        step();
        chk("t3_count_3to3", dfq.count, 3);

        // 4: flush at count 3 drops everything including this ihit
        drive(1'b1, 32'h2000_00C0, 32'h500);
        dfq.flush = 1'b1;
        step();
        exp_q.delete();
        dfq.flush = 1'b0;
        chk("t4_count", dfq.count, 0);
        chk("t4_valid", dfq.out_valid, 0);
        chk("t4_instr", dfq.instr_out, 0);
        drive(1'b1, 32'h2400_0001, 32'h600);
        expect_entry(32'h2400_0001, 32'h600);
        step();
        chk("t4_after_flush", dfq.instr_out, 32'h2400_0001);
        drive(1'b0, '0, '0);
        step();

        // 5: sticky halt
        dfq.stall = 1'b1;
        drive(1'b1, 32'h8C00_0010, 32'h700);
        expect_entry(32'h8C00_0010, 32'h700);
        step();
        drive(1'b1, 32'hFC00_0000, 32'h704);
        expect_entry(32'hFC00_0000, 32'h704);
        step();
        chk("t5_halt", dfq.halt, 1);
        chk("t5_ready", dfq.in_ready, 0);
        drive(1'b1, 32'h8C00_0020, 32'h708);
        step();
        chk("t5_no_push", dfq.count, 2);
        drive(1'b0, '0, '0);
        dfq.stall = 1'b0;
        step();
        chk("t5_halt_head", dfq.instr_out, 32'hFC00_0000);
        step();
        chk("t5_drained", {dfq.count, dfq.halt, dfq.in_ready}, {3'd0, 1'b1, 1'b0});
        dfq.flush = 1'b1;
        step();
        dfq.flush = 1'b0;
        chk("t5_flush_halt", {dfq.halt, dfq.in_ready}, {1'b0, 1'b1});

        // 6: wrap with 2*DEPTH+1 push/pop pairs, then reset mid-stream
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            drive(1'b1, 32'h3000_0000 + i, 32'h800 + 32'(4 * i));
            expect_entry(32'h3000_0000 + i, 32'h800 + 32'(4 * i));
            step();
            chk("t6_wrap_head", dfq.instr_out, 32'h3000_0000 + i);
        end
        drive(1'b0, '0, '0);
        step();
        dfq.stall = 1'b1;
        drive(1'b1, 32'h3100_0000, 32'h880);
        expect_entry(32'h3100_0000, 32'h880);
        step();
        drive(1'b1, 32'hFC00_0001, 32'h884);
        expect_entry(32'hFC00_0001, 32'h884);
        step();
        chk("t6_pre_rst", {dfq.count, dfq.halt}, {3'd2, 1'b1});
        nRST = 1'b0;
        drive(1'b1, 32'h3200_0000, 32'h888);
        step();
        exp_q.delete();
        chk("t6_rst_state", {dfq.count, dfq.out_valid, dfq.halt, dfq.in_ready},
            {3'd0, 1'b0, 1'b0, 1'b1});
        chk("t6_rst_instr", dfq.instr_out, 0);
        nRST = 1'b1;
        dfq.stall = 1'b0;
        drive(1'b1, 32'h3300_0000, 32'h900);
        expect_entry(32'h3300_0000, 32'h900);
        step();
        chk("t6_post_rst", dfq.instr_out, 32'h3300_0000);
        drive(1'b0, '0, '0);
        step();
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
